add_seq_ctrl: RTL and testbench
===============================

Name: add_seq_ctrl

Overview:
- Clocked sequencer driving one shared dual-rail integer adder link from a synchronous valid/ready domain.
- Accepts binary operands, drives them onto the adder's dual-rail inputs and waits for completion. Captures the sum and carry, then returns the link to spacer and presents the result back to the clocked domain.
- Supports carry chaining across consecutive operations for multi-word additions.
- Sits between the clocked host datapath and the async adder instance.

Parameters:
- WIDTH, 8, operand/sum width in bits; equals the adder's WIDTH.
- SYNC_STAGES, 2, flop depth of the synchronisers on adder_ack_o and on the result-complete/result-null detect signals; minimum 2.
- TIMEOUT, 1024, watchdog limit in clk cycles per async phase; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  host request valid.
- in_ready  out  1  controller can accept a request.
- in_a  in  WIDTH  operand A, binary.
- in_b  in  WIDTH  operand B, binary.
- in_cin  in  1  carry-in, used when in_chain=0.
- in_chain  in  1  1 selects the stored carry from the previous operation as carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  host accepts result.
- out_sum  out  WIDTH  binary sum.
- out_cout  out  1  binary carry-out.
- err  out  1  sticky watchdog error; constant 0 without the optional feature.
- adder_a, adder_b  out  WIDTH*2  dual-rail operands: rail1=true, rail0=false, 00=spacer.
- adder_cin  out  2  dual-rail carry-in.
- adder_ack_o  in  1  adder input acknowledge (async).
- adder_ack_i  out  1  acknowledge to the adder that its output is consumed.
- adder_s  in  WIDTH*2  dual-rail sum (async).
- adder_cout  in  2  dual-rail carry-out (async).

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0.
  - Stored carry=0, err=0, adder_ack_i=0.
  - All dual-rail outputs are spacer (00).
- Detect logic (combinational on adder outputs):
  - complete = every bit of adder_s and adder_cout has exactly one rail high.
  - null = all rails low.
  - complete, null and adder_ack_o each pass through SYNC_STAGES flops before the FSM uses them.
- IDLE:
  - in_ready=1.
  - On in_valid: register the dual-rail encoding of in_a, in_b and cin (cin = stored carry if in_chain, else in_cin) onto adder_* outputs in the same edge; go to EVAL.
- EVAL:
  - Data held stable, adder_ack_i=0.
  - When synced adder_ack_o=1 and synced complete=1, decode adder_s/adder_cout (rail1) into out_sum/out_cout and the stored carry. Decoding is safe because the data is held stable.
  - In the same edge, drive all adder_* inputs to spacer and set adder_ack_i=1; go to RTZ.
- RTZ:
  - When synced adder_ack_o=0 and synced null=1, set adder_ack_i=0 and out_valid=1; go to RESP.
- RESP:
  - out_valid=1; result held.
  - On out_ready, out_valid=0; go to IDLE.
- in_ready=1 only in IDLE.
  - Minimum latency from accept to out_valid is 2*(SYNC_STAGES+1) cycles plus adder delay.
  - One operation in flight at a time.
- in_chain=1 on the first operation after reset uses carry 0.
- Stored carry updates only on a capture in EVAL.
- An illegal rail code 11 never counts as complete; such a transfer stalls in EVAL.
- Reset asserted mid-operation: immediate return to reset values; the adder link is forced to spacer asynchronously.
- in_valid deasserting while in IDLE has no effect; the request must be held until accepted.

Optional Feature:
- Macro ADD_SEQ_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on every state entry and counts while in EVAL or RTZ.
  - On reaching TIMEOUT: set err=1 (sticky until reset), drive spacer, set adder_ack_i=0, go to IDLE. out_valid is not asserted for that operation.
- When undefined:
  - No counter; err tied 0.
  - EVAL/RTZ wait indefinitely.

Test Plan:
- WIDTH=8: a=0x3C, b=0x05, cin=0, chain=0 -> out_sum=0x41, out_cout=0, one out_valid pulse. Link returns to all-spacer and adder_ack_i=0 before out_valid.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Next request a=0x00, b=0x00, chain=1 -> sum=0x01, cout=0.
- Hold out_ready=0 for 20 cycles in RESP -> out_valid/out_sum stable, in_ready=0, second in_valid not accepted; then out_ready=1 -> in_ready=1 next cycle.
- Adder model delays ack by 50 cycles -> controller remains in EVAL with data stable, then result 0xAA+0x55+1 = 0x00, cout=1.
- Assert rst low while in RTZ -> adder_* spacer and adder_ack_i=0 immediately, out_valid=0, stored carry=0; after release, chain=1 uses carry 0.
- With ADD_SEQ_TIMEOUT_EN and TIMEOUT=16, adder never acks -> err=1 at cycle 16 after EVAL entry, state IDLE, in_ready=1, no out_valid; err stays 1 until reset.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Clocked valid/ready sequencer for one shared dual-rail adder link. Per bit: rail1=[2i+1], rail0=[2i].
// Optional watchdog on the EVAL/RTZ phases is enabled by defining ADD_SEQ_TIMEOUT_EN.
module add_seq_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic               in_chain,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_cout,
    output logic               err,
    output logic [2*WIDTH-1:0] adder_a,
    output logic [2*WIDTH-1:0] adder_b,
    output logic [1:0]         adder_cin,
    input  logic               adder_ack_o,
    output logic               adder_ack_i,
    input  logic [2*WIDTH-1:0] adder_s,
    input  logic [1:0]         adder_cout
);

    typedef enum logic [1:0] {IDLE, EVAL, RTZ, RESP} state_t;

    function automatic logic [2*WIDTH-1:0] dr_encode(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] dr_decode(input logic [2*WIDTH-1:0] r);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) v[i] = r[2*i+1];
        return v;
    endfunction

    state_t             state_q;
    logic               in_ready_q, out_valid_q, out_cout_q, carry_q, ack_i_q;
    logic [WIDTH-1:0]   out_sum_q;
    logic [2*WIDTH-1:0] a_q, b_q;
    logic [1:0]         cin_q;

    logic complete_raw, null_raw;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        complete_raw = adder_cout[1] ^ adder_cout[0];
        for (int i = 0; i < WIDTH; i++) begin
            complete_raw = complete_raw & (adder_s[2*i+1] ^ adder_s[2*i]);
        end
    end

    assign null_raw = ~|{adder_s, adder_cout};

    logic [SYNC_STAGES-1:0] ack_sync_q, comp_sync_q, null_sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_sync_q  <= '0;
            comp_sync_q <= '0;
            null_sync_q <= '0;
        end else begin
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], adder_ack_o};
            comp_sync_q <= {comp_sync_q[SYNC_STAGES-2:0], complete_raw};
            null_sync_q <= {null_sync_q[SYNC_STAGES-2:0], null_raw};
        end
    end

    logic eval_done, rtz_done, timeout_hit;

    assign eval_done = (state_q == EVAL) && ack_sync_q[SYNC_STAGES-1] && comp_sync_q[SYNC_STAGES-1];
    assign rtz_done  = (state_q == RTZ) && !ack_sync_q[SYNC_STAGES-1] && null_sync_q[SYNC_STAGES-1];

`ifdef ADD_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign timeout_hit = ((state_q == EVAL) || (state_q == RTZ)) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counter restarts on every state change, so each async phase gets its own budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (((state_q == EVAL) || (state_q == RTZ)) && !eval_done && !rtz_done && !timeout_hit)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            err_q <= err_q | timeout_hit;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Reset drives the link to spacer asynchronously through the flop resets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            carry_q     <= 1'b0;
            ack_i_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 2'b00;
        end else if (timeout_hit) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 2'b00;
            ack_i_q    <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= dr_encode(in_a);
                    b_q        <= dr_encode(in_b);
                    cin_q      <= in_chain ? {carry_q, ~carry_q} : {in_cin, ~in_cin};
                    in_ready_q <= 1'b0;
                    state_q    <= EVAL;
                end
                EVAL: if (eval_done) begin
                    out_sum_q  <= dr_decode(adder_s);
                    out_cout_q <= adder_cout[1];
                    carry_q    <= adder_cout[1];
                    a_q        <= '0;
                    b_q        <= '0;
                    cin_q      <= 2'b00;
                    ack_i_q    <= 1'b1;
                    state_q    <= RTZ;
                end
                RTZ: if (rtz_done) begin
                    ack_i_q     <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_cout    = out_cout_q;
    assign adder_a     = a_q;
    assign adder_b     = b_q;
    assign adder_cin   = cin_q;
    assign adder_ack_i = ack_i_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomised bench for add_seq_ctrl with a behavioural dual-rail adder and an arithmetic reference model.
// Adds a watchdog test when ADD_SEQ_TIMEOUT_EN is defined.
module tb_add_seq_ctrl;

    localparam int W  = 8;
    localparam int SS = 2;
`ifdef ADD_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0, in_cin = 1'b0, in_chain = 1'b0, out_ready = 1'b0;
    logic [W-1:0]   in_a = '0, in_b = '0;
    logic           in_ready, out_valid, out_cout, err, adder_ack_i;
    logic [W-1:0]   out_sum;
    logic [2*W-1:0] adder_a, adder_b;
    logic [1:0]     adder_cin;
    logic           adder_ack_o;
    logic [2*W-1:0] adder_s;
    logic [1:0]     adder_cout;

    int checks = 0;
    int errors = 0;

    add_seq_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .err(err),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_ack_o(adder_ack_o), .adder_ack_i(adder_ack_i),
        .adder_s(adder_s), .adder_cout(adder_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] rails(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [W:0] true_rails(input logic [2*W-1:0] r);
        logic [W:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i] = r[2*i+1];
        return v;
    endfunction

    function automatic bit one_hot_all(input logic [2*W-1:0] r);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < W; i++) ok = ok && (r[2*i+1] != r[2*i]);
        return ok;
    endfunction

    // Behavioural adder: delays m_delay cycles per phase; m_never suppresses the ack forever.
    int         m_delay = 0;
    bit         m_never = 1'b0;
    int         m_cnt;
    logic [W:0] m_res;
    logic       m_in_complete, m_in_null;

    assign m_res         = true_rails(adder_a) + true_rails(adder_b) + {{W{1'b0}}, adder_cin[1]};
    assign m_in_complete = one_hot_all(adder_a) && one_hot_all(adder_b) && (adder_cin[1] != adder_cin[0]);
    assign m_in_null     = (adder_a == '0) && (adder_b == '0) && (adder_cin == 2'b00);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            adder_s     <= '0;
            adder_cout  <= 2'b00;
            adder_ack_o <= 1'b0;
            m_cnt       <= 0;
        end else if (!adder_ack_o) begin
            if (m_in_complete && !adder_ack_i && !m_never) begin
                if (m_cnt >= m_delay) begin
                    adder_s     <= rails(m_res[W-1:0]);
                    adder_cout  <= m_res[W] ? 2'b10 : 2'b01;
                    adder_ack_o <= 1'b1;
                    m_cnt       <= 0;
                end else m_cnt <= m_cnt + 1;
            end else m_cnt <= 0;
        end else begin
            if (m_in_null && adder_ack_i) begin
                if (m_cnt >= m_delay) begin
                    adder_s     <= '0;
                    adder_cout  <= 2'b00;
                    adder_ack_o <= 1'b0;
                    m_cnt       <= 0;
                end else m_cnt <= m_cnt + 1;
            end else m_cnt <= 0;
        end
    end

    // Reference state: carry left by the last completed addition.
    logic ref_carry = 1'b0;

    task automatic accept(input logic [W-1:0] a, b, input logic cin, chain, input string tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        check({tag, "_ready"}, in_ready, 1'b1);
        in_a = a; in_b = b; in_cin = cin; in_chain = chain; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 1'b0);
        check({tag, "_drv_a"}, adder_a, rails(a));
    endtask

    task automatic run_op(input logic [W-1:0] a, b, input logic cin, chain,
                          input int delay, input int hold, input string tag);
        logic [W:0] exp;
        logic       c;
        int         lat = 0;
        m_delay = delay;
        c   = chain ? ref_carry : cin;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        accept(a, b, cin, chain, tag);
        if (delay >= 40) begin
            repeat (40) @(negedge clk);
            check({tag, "_eval_a"}, adder_a, rails(a));
            check({tag, "_eval_b"}, adder_b, rails(b));
            check({tag, "_eval_ov"}, out_valid, 1'b0);
            lat = 40;
        end
        while (!out_valid && lat < 500) begin @(negedge clk); lat++; end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_minlat"}, lat >= 2 * (SS + 1), 1'b1);
        check({tag, "_spacer"}, {adder_a, adder_b, adder_cin, adder_ack_i}, '0);
        check({tag, "_sum"}, out_sum, exp[W-1:0]);
        check({tag, "_cout"}, out_cout, exp[W]);
        ref_carry = exp[W];
        if (hold > 0) begin
            in_a = ~a; in_b = b; in_valid = 1'b1;
            repeat (hold) @(negedge clk);
            check({tag, "_hold_ov"}, out_valid, 1'b1);
            check({tag, "_hold_sum"}, {out_cout, out_sum}, exp);
            check({tag, "_hold_rdy"}, in_ready, 1'b0);
            check({tag, "_hold_link"}, adder_a, '0);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #12;
        check("rst_ready", in_ready, 1'b1);
        check("rst_outs", {out_valid, out_sum, out_cout, err, adder_ack_i}, '0);
        check("rst_link", {adder_a, adder_b, adder_cin}, '0);
        @(negedge clk); rst = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 1'b1, 1, 0, "chain_first");
        run_op(8'h3C, 8'h05, 1'b0, 1'b0, 2, 0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, "wrap");
        run_op(8'h00, 8'h00, 1'b0, 1'b1, 3, 0, "chain");
        run_op(8'h12, 8'h34, 1'b1, 1'b0, 1, 20, "resp_hold");
        run_op(8'hAA, 8'h55, 1'b1, 1'b0, 50, 0, "slow_ack");
        run_op(8'h01, 8'h01, 1'b0, 1'b1, 0, 0, "chain_after_slow");

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 6), $urandom_range(0, 3), "rand");
        end

        // Reset while in RTZ, after the carry from 0xFF+0x01 has been captured.
        begin
            int n = 0;
            m_delay = 30;
            accept(8'hFF, 8'h01, 1'b0, 1'b0, "rtz_rst");
            while (!adder_ack_i && n < 200) begin @(negedge clk); n++; end
            check("rtz_rst_in_rtz", adder_ack_i, 1'b1);
            repeat (5) @(negedge clk);
            #2 rst = 1'b0;
            #1;
            check("rtz_rst_link", {adder_a, adder_b, adder_cin, adder_ack_i}, '0);
            check("rtz_rst_outs", {out_valid, in_ready}, 2'b01);
            ref_carry = 1'b0;
            @(negedge clk); rst = 1'b1;
            run_op(8'h10, 8'h20, 1'b1, 1'b1, 1, 0, "post_rst_chain");
        end

`ifdef ADD_SEQ_TIMEOUT_EN
        m_never = 1'b1;
        accept(8'h11, 8'h22, 1'b0, 1'b0, "wd");
        repeat (TO - 1) @(posedge clk);
        #1 check("wd_before", err, 1'b0);
        @(posedge clk); #1;
        check("wd_err", err, 1'b1);
        check("wd_idle", {in_ready, out_valid, adder_ack_i}, 3'b100);
        check("wd_link", {adder_a, adder_b, adder_cin}, '0);
        repeat (10) @(negedge clk);
        check("wd_sticky", {err, out_valid}, 2'b10);
        m_never = 1'b0;
        rst = 1'b0;
        #1 check("wd_rst_clear", err, 1'b0);
        ref_carry = 1'b0;
        @(negedge clk); rst = 1'b1;
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1, 0, "wd_recover");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
